// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the RAM arbiter slice.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 24;
    localparam int DEF_DATA_W = 16;

    // Requester indices
    localparam int REQ_SPI  = 0;
    localparam int REQ_CART = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_ACCEPT   = 2'd2,
        ST_COMPLETE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: two-way grant selection.
// Build macro RAM_ARB_FIXED_PRIO_EN: cart requester always wins a tie and
// i_last_grant is ignored; otherwise ties alternate (round-robin).
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_valid,
    output logic       o_idx
);

    // Sole requester wins; a tie is resolved by the configured policy.
    always_comb begin
        o_valid = |i_req;
        o_idx   = i_req[REQ_CART];
`ifndef RAM_ARB_FIXED_PRIO_EN
        if (i_req[REQ_SPI] && i_req[REQ_CART]) begin
            o_idx = ~i_last_grant;
        end
`endif
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates SPI loader and cart bus onto one memory controller
// with a single outstanding transfer and a completion timeout.
// Build macro RAM_ARB_FIXED_PRIO_EN selects fixed tie priority (cart wins).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        m_req,
    input  logic [1:0]        m_we,
    input  logic [ADDR_W-1:0] m_addr0,
    input  logic [ADDR_W-1:0] m_addr1,
    input  logic [DATA_W-1:0] m_wdata0,
    input  logic [DATA_W-1:0] m_wdata1,
    output logic [1:0]        m_ack,
    output logic [1:0]        m_err,
    output logic [DATA_W-1:0] m_rdata,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_enable,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_enable,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    input  logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_idx;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wr_en;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [1:0]        r_ack;
    logic [1:0]        r_err;
    logic [DATA_W-1:0] r_rdata;

    logic w_pick_vld;
    logic w_pick_idx;
    logic w_in_xfer;
    logic w_grant;
    logic w_issue;
    logic w_accept;
    logic w_done;
    logic w_tmo;

    ram_arb_pick u_pick (
        .i_req        (m_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_pick_vld),
        .o_idx        (w_pick_idx)
    );

    // Next-state and per-cycle event decode. A normal completion beats a
    // timeout landing on the same cycle; no grant during the ack cycle.
    always_comb begin
        w_next_state = r_state;
        w_in_xfer    = (r_state == ST_ACCEPT) || (r_state == ST_COMPLETE);
        w_grant      = 1'b0;
        w_issue      = 1'b0;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_tmo        = w_in_xfer && (r_cnt == CNT_W'(TIMEOUT - 1));
        case (r_state)
            ST_IDLE: begin
                w_grant = w_pick_vld && (r_ack == 2'b00);
                if (w_grant) w_next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_issue = !busy;
                if (w_issue) w_next_state = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                if (w_tmo) begin
                    w_next_state = ST_IDLE;
                end else if (busy) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_COMPLETE;
                end
            end
            ST_COMPLETE: begin
                w_done = r_we ? !busy : rd_ready;
                if (w_done) begin
                    w_tmo        = 1'b0;
                    w_next_state = ST_IDLE;
                end else if (w_tmo) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Datapath: latch the winner, drive the controller ports, count, complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_wr_en      <= 1'b0;
            r_rd_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_rd_addr    <= '0;
            r_ack        <= 2'b00;
            r_err        <= 2'b00;
            r_rdata      <= '0;
        end else begin
            r_ack <= 2'b00;
            r_err <= 2'b00;
            if (w_grant) begin
                r_idx   <= w_pick_idx;
                r_we    <= m_we[w_pick_idx];
                r_addr  <= w_pick_idx ? m_addr1 : m_addr0;
                r_wdata <= w_pick_idx ? m_wdata1 : m_wdata0;
            end
            if (w_issue) begin
                r_wr_en <= r_we;
                r_rd_en <= !r_we;
                r_cnt   <= '0;
                if (r_we) begin
                    r_wr_addr <= r_addr;
                    r_wr_data <= r_wdata;
                end else begin
                    r_rd_addr <= r_addr;
                end
            end
            if (w_in_xfer) r_cnt <= r_cnt + CNT_W'(1);
            if (w_accept) begin
                r_wr_en <= 1'b0;
                r_rd_en <= 1'b0;
            end
            if (w_done || w_tmo) begin
                r_wr_en        <= 1'b0;
                r_rd_en        <= 1'b0;
                r_ack[r_idx]   <= 1'b1;
                r_err[r_idx]   <= w_tmo;
                r_last_grant   <= r_idx;
                if (w_done && !r_we) r_rdata <= rd_data;
            end
        end
    end

    assign m_ack     = r_ack;
    assign m_err     = r_err;
    assign m_rdata   = r_rdata;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign wr_enable = r_wr_en;
    assign rd_addr   = r_rd_addr;
    assign rd_enable = r_rd_en;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors plus hand-written corner sequences.
module tb_ram_arbiter;

    localparam int AW  = 24;
    localparam int DW  = 16;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    m_req, m_we;
    logic [AW-1:0] m_addr0, m_addr1;
    logic [DW-1:0] m_wdata0, m_wdata1;
    logic [1:0]    m_ack, m_err;
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_enable, rd_enable;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we),
        .m_addr0(m_addr0), .m_addr1(m_addr1),
        .m_wdata0(m_wdata0), .m_wdata1(m_wdata1),
        .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
        .rd_addr(rd_addr), .rd_enable(rd_enable),
        .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory controller model: busy rises the edge after an enable is seen,
    // stays high busy_len cycles; reads return rd_ready rd_gap cycles after
    // busy rises. never_busy models a dead controller.
    logic          never_busy = 1'b0;
    logic          busy_force = 1'b0;
    int            busy_len   = 3;
    int            rd_gap     = 5;
    logic [DW-1:0] mdl_rdval  = '0;
    logic          busy_m, mdl_act, mdl_rd;
    int            mdl_cnt;

    assign busy = busy_m | busy_force;

    always @(posedge clk) begin
        if (rst) begin
            busy_m <= 1'b0; rd_ready <= 1'b0; rd_data <= '0;
            mdl_act <= 1'b0; mdl_rd <= 1'b0; mdl_cnt <= 0;
        end else begin
            rd_ready <= 1'b0;
            if (never_busy) rd_data <= mdl_rdval;
            if (!mdl_act) begin
                if ((wr_enable || rd_enable) && !never_busy) begin
                    mdl_act <= 1'b1; busy_m <= 1'b1; mdl_cnt <= 1; mdl_rd <= rd_enable;
                end
            end else begin
                mdl_cnt <= mdl_cnt + 1;
                if (mdl_cnt == busy_len) busy_m <= 1'b0;
                if (mdl_rd && mdl_cnt == rd_gap) begin
                    rd_ready <= 1'b1; rd_data <= mdl_rdval;
                end
                if (mdl_cnt >= busy_len && (!mdl_rd || mdl_cnt >= rd_gap)) mdl_act <= 1'b0;
            end
        end
    end

    // Enable monitor, sampled on the falling edge.
    int            wr_seen = 0, rd_seen = 0, overlap = 0;
    logic [AW-1:0] cap_wr_addr = '0, cap_rd_addr = '0;
    logic [DW-1:0] cap_wr_data = '0;

    always @(negedge clk) begin
        if (wr_enable && rd_enable) overlap++;
        if (wr_enable) begin wr_seen++; cap_wr_addr = wr_addr; cap_wr_data = wr_data; end
        if (rd_enable) begin rd_seen++; cap_rd_addr = rd_addr; end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ack(input string nm, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (m_ack == 2'b00 && lat < 60);
        chk({nm, "_ack_seen"}, 32'(m_ack != 2'b00), 32'd1);
    endtask

    task automatic drive_req(input logic idx, input logic we,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_req[idx] = 1'b1;
        m_we[idx]  = we;
        if (idx) begin m_addr1 = a; m_wdata1 = d; end
        else     begin m_addr0 = a; m_wdata0 = d; end
    endtask

    typedef struct {
        logic          idx;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdval;
        logic [1:0]    exp_ack;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int            lat, wr0, rd0, bad, k;
        logic [3:0]    tie_seq;
        logic          post_win;
`ifdef RAM_ARB_FIXED_PRIO_EN
        tie_seq  = 4'b1111;
        post_win = 1'b1;
`else
        tie_seq  = 4'b1010;
        post_win = 1'b0;
`endif
        //           idx   we    addr        wdata     rdval     ack    rdata     lat
        vecs[0] = '{1'b0, 1'b1, 24'h123456, 16'hBEEF, 16'h0000, 2'b01, 16'h0000, 7};
        vecs[1] = '{1'b1, 1'b0, 24'h000010, 16'h0000, 16'hCAFE, 2'b10, 16'hCAFE, 9};
        vecs[2] = '{1'b1, 1'b1, 24'hABCDEF, 16'h1234, 16'h0000, 2'b10, 16'hCAFE, 7};
        vecs[3] = '{1'b0, 1'b0, 24'h00FF00, 16'h0000, 16'h5A5A, 2'b01, 16'h5A5A, 9};

        rst = 1'b1; m_req = '0; m_we = '0;
        m_addr0 = '0; m_addr1 = '0; m_wdata0 = '0; m_wdata1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack",   32'(m_ack), 32'd0);
        chk("rst_err",   32'(m_err), 32'd0);
        chk("rst_rdata", 32'(m_rdata), 32'd0);
        chk("rst_wr_en", 32'(wr_enable), 32'd0);
        chk("rst_rd_en", 32'(rd_enable), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        rst = 1'b0;

        // Tie: both requesters held across four transfers.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 24'h111111, 16'h1111);
        drive_req(1'b1, 1'b1, 24'h222222, 16'h2222);
        for (int t = 0; t < 4; t++) begin
            wait_ack($sformatf("tie%0d", t), lat);
            chk($sformatf("tie%0d_grant", t), 32'(m_ack), tie_seq[t] ? 32'd2 : 32'd1);
            chk($sformatf("tie%0d_err", t), 32'(m_err), 32'd0);
        end
        m_req = '0;

        // Single-requester vectors.
        for (int i = 0; i < 4; i++) begin
            busy_len  = vecs[i].we ? 3 : 2;
            rd_gap    = 5;
            mdl_rdval = vecs[i].rdval;
            @(negedge clk);
            wr0 = wr_seen; rd0 = rd_seen;
            drive_req(vecs[i].idx, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            wait_ack($sformatf("v%0d", i), lat);
            chk($sformatf("v%0d_ack", i),   32'(m_ack), 32'(vecs[i].exp_ack));
            chk($sformatf("v%0d_err", i),   32'(m_err), 32'd0);
            chk($sformatf("v%0d_lat", i),   32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_rdata", i), 32'(m_rdata), 32'(vecs[i].exp_rdata));
            if (vecs[i].we) begin
                chk($sformatf("v%0d_wr_seen", i), 32'(wr_seen > wr0), 32'd1);
                chk($sformatf("v%0d_wr_addr", i), 32'(cap_wr_addr), 32'(vecs[i].addr));
                chk($sformatf("v%0d_wr_data", i), 32'(cap_wr_data), 32'(vecs[i].wdata));
                chk($sformatf("v%0d_no_rd", i),   32'(rd_seen - rd0), 32'd0);
            end else begin
                chk($sformatf("v%0d_rd_seen", i), 32'(rd_seen > rd0), 32'd1);
                chk($sformatf("v%0d_rd_addr", i), 32'(cap_rd_addr), 32'(vecs[i].addr));
                chk($sformatf("v%0d_no_wr", i),   32'(wr_seen - wr0), 32'd0);
            end
            m_req = '0;
            @(negedge clk);
            chk($sformatf("v%0d_ack_pulse", i), 32'(m_ack), 32'd0);
        end

        // Timeout: dead controller on a read; m_rdata must stay put.
        never_busy = 1'b1;
        mdl_rdval  = 16'hDEAD;
        @(negedge clk);
        rd0 = rd_seen;
        drive_req(1'b0, 1'b0, 24'h000020, 16'h0000);
        wait_ack("tmo", lat);
        chk("tmo_lat",   32'(lat), 32'd10);
        chk("tmo_ack",   32'(m_ack), 32'd1);
        chk("tmo_err",   32'(m_err), 32'd1);
        chk("tmo_rd_en", 32'(rd_enable), 32'd0);
        chk("tmo_en_cycles", 32'(rd_seen - rd0), 32'd8);
        chk("tmo_rdata", 32'(m_rdata), 32'h5A5A);
        m_req = '0;
        @(negedge clk);
        chk("tmo_err_pulse", 32'(m_err), 32'd0);

        // Reset while in ACCEPT.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 24'h0ABCDE, 16'h7777);
        k = 0;
        do begin @(negedge clk); k++; end while (!wr_enable && k < 10);
        chk("rstacc_reached", 32'(wr_enable), 32'd1);
        rst = 1'b1; m_req = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("rstacc_wr_en", 32'(wr_enable), 32'd0);
        chk("rstacc_rd_en", 32'(rd_enable), 32'd0);
        chk("rstacc_ack",   32'(m_ack), 32'd0);
        chk("rstacc_rdata", 32'(m_rdata), 32'd0);
        bad = 0;
        repeat (3) begin @(negedge clk); if (m_ack != 2'b00 || wr_enable) bad++; end
        chk("rstacc_quiet", 32'(bad), 32'd0);
        never_busy = 1'b0;
        busy_len   = 3;
        drive_req(1'b0, 1'b1, 24'h000100, 16'h0101);
        drive_req(1'b1, 1'b1, 24'h000200, 16'h0202);
        wait_ack("rstacc_tie", lat);
        chk("rstacc_tie_grant", 32'(m_ack), post_win ? 32'd2 : 32'd1);
        m_req = '0;

        // Controller busy before ISSUE: no enable until it drops.
        @(negedge clk);
        busy_force = 1'b1;
        wr0 = wr_seen;
        drive_req(1'b1, 1'b1, 24'h00CAFE, 16'h4321);
        bad = 0;
        repeat (6) begin @(negedge clk); if (wr_enable || rd_enable) bad++; end
        chk("busyiss_no_en", 32'(bad), 32'd0);
        busy_force = 1'b0;
        wait_ack("busyiss", lat);
        chk("busyiss_ack",     32'(m_ack), 32'd2);
        chk("busyiss_err",     32'(m_err), 32'd0);
        chk("busyiss_wr_seen", 32'(wr_seen > wr0), 32'd1);
        chk("busyiss_wr_addr", 32'(cap_wr_addr), 32'h00CAFE);
        m_req = '0;
        @(negedge clk);

        chk("enable_overlap", 32'(overlap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
